muldiv_sequencer: RTL and testbench

//  Multi-cycle unsigned MUL/DIV unit with HI/LO result registers, beside the single-cycle ALU.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/muldiv_sequencer.sv | 134 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes and the MUL/DIV sequencer state type.
package cpu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_MUL = 4'b0101;
    localparam logic [3:0] ALU_DIV = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned MUL/DIV unit: one bit per cycle, results held in HI/LO.
module muldiv_sequencer
    import cpu_pkg::*;
#(
    parameter int N = 32,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [M-1:0] alu_decode,
    input  logic [N-1:0] rda,
    input  logic [N-1:0] rdx,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         div_zero
);

    localparam int CW = $clog2(N);

    muldiv_state_t    state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*N-1:0]   work_q, work_d;
    logic [N-1:0]     opnd_q, opnd_d;
    logic [N-1:0]     hi_q, hi_d;
    logic [N-1:0]     lo_q, lo_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             is_mul;
    logic             is_div;
    logic             accept;
    logic [N:0]       mul_sum;
    logic [2*N-1:0]   mul_next;
    logic [N:0]       rem_sh;
    logic             rem_ge;
    logic [N:0]       rem_new;
    logic [2*N-1:0]   div_next;

    assign is_mul = (alu_decode == M'(ALU_MUL));
    assign is_div = (alu_decode == M'(ALU_DIV));
    assign accept = start && (is_mul || is_div)
                    && (state_q == IDLE || state_q == DONE);

    // MUL: work = {partial, multiplier}; add on LSB then shift right with carry.
    assign mul_sum  = {1'b0, work_q[2*N-1:N]}
                      + (work_q[0] ? {1'b0, opnd_q} : {(N+1){1'b0}});
    assign mul_next = {mul_sum, work_q[N-1:1]};

    // DIV: work = {rem, dividend}; N+1-bit compare keeps the shifted-out bit.
    assign rem_sh   = {work_q[2*N-1:N], work_q[N-1]};
    assign rem_ge   = (rem_sh >= {1'b0, opnd_q});
    assign rem_new  = rem_ge ? (rem_sh - {1'b0, opnd_q}) : rem_sh;
    assign div_next = {rem_new[N-1:0], work_q[N-2:0], rem_ge};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    state_d = is_mul ? MUL : DIV;
                    cnt_d   = CW'(N-1);
                    work_d  = {{N{1'b0}}, (is_mul ? rdx : rda)};
                    opnd_d  = is_mul ? rda : rdx;
                end
            end
            MUL: begin
                work_d = mul_next;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    hi_d    = mul_next[2*N-1:N];
                    lo_d    = mul_next[N-1:0];
                    dz_d    = 1'b0;
                    state_d = DONE;
                end
            end
            DIV: begin
                work_d = div_next;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    hi_d    = div_next[2*N-1:N];
                    lo_d    = div_next[N-1:0];
                    dz_d    = (opnd_q == '0);
                    state_d = DONE;
                end
            end
        endcase
        busy_d = (state_d == MUL) || (state_d == DIV);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: arithmetic model plus directed vectors.
module tb_muldiv_sequencer;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  alu_decode = 4'd0;
    logic [31:0] rda = '0;
    logic [31:0] rdx = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int n_pass = 0;
    int n_total = 0;

    muldiv_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .alu_decode(alu_decode), .rda(rda), .rdx(rdx),
        .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Model: an accepted op keeps the unit busy for N cycles, then the
    // arithmetic result appears together with a single done cycle.
    int          m_rem = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_dz = 1'b0;
    logic [31:0] p_hi = '0, p_lo = '0;
    logic        p_dz = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_dz   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_rem > 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_hi   <= p_hi;
                    m_lo   <= p_lo;
                    m_dz   <= p_dz;
                    m_done <= 1'b1;
                end
            end else if (start && alu_decode == 4'd5) begin
                logic [63:0] prod;
                prod = {32'd0, rda} * {32'd0, rdx};
                p_hi  <= prod[63:32];
                p_lo  <= prod[31:0];
                p_dz  <= 1'b0;
                m_rem <= N;
            end else if (start && alu_decode == 4'd6) begin
                if (rdx == 0) begin
                    p_hi <= rda;
                    p_lo <= 32'hFFFF_FFFF;
                    p_dz <= 1'b1;
                end else begin
                    p_hi <= rda % rdx;
                    p_lo <= rda / rdx;
                    p_dz <= 1'b0;
                end
                m_rem <= N;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", 64'(busy), 64'(m_rem > 0));
            check("done", 64'(done), 64'(m_done));
            check("hi", 64'(hi), 64'(m_hi));
            check("lo", 64'(lo), 64'(m_lo));
            check("div_zero", 64'(div_zero), 64'(m_dz));
        end
    end

    // Called at a negedge; presents start now and waits for done.
    // inj > 0 pulses a DIV 9/3 request at that cycle of the run.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] x, input int inj,
                          output int lat, output int bsy);
        start = 1'b1;
        alu_decode = op;
        rda = a;
        rdx = x;
        lat = 0;
        bsy = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            start = 1'b0;
            rda = $urandom;
            rdx = $urandom;
            if (lat == inj) begin
                start = 1'b1;
                alu_decode = 4'd6;
                rda = 32'd9;
                rdx = 32'd3;
            end
            if (busy) bsy++;
            if (done) break;
            if (lat > 60) begin
                check("done_timeout", 64'(lat), 64'd33);
                break;
            end
        end
    endtask

    int lat, bsy;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_dz", 64'(div_zero), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, bsy);
        check("mul_ff_lat", 64'(lat), 64'd33);
        check("mul_ff_busy", 64'(bsy), 64'd32);
        check("mul_ff_hi", 64'(hi), 64'hFFFF_FFFE);
        check("mul_ff_lo", 64'(lo), 64'h0000_0001);

        @(negedge clk);
        run_op(4'd6, 32'd100, 32'd7, 0, lat, bsy);
        check("div_100_7_lo", 64'(lo), 64'd14);
        check("div_100_7_hi", 64'(hi), 64'd2);
        check("div_100_7_dz", 64'(div_zero), 64'd0);

        @(negedge clk);
        run_op(4'd6, 32'd5, 32'd9, 0, lat, bsy);
        check("div_5_9_lo", 64'(lo), 64'd0);
        check("div_5_9_hi", 64'(hi), 64'd5);

        @(negedge clk);
        run_op(4'd6, 32'h1234_5678, 32'd0, 0, lat, bsy);
        check("div0_lo", 64'(lo), 64'hFFFF_FFFF);
        check("div0_hi", 64'(hi), 64'h1234_5678);
        check("div0_dz", 64'(div_zero), 64'd1);
        check("div0_lat", 64'(lat), 64'd33);

        @(negedge clk);
        run_op(4'd5, 32'd3, 32'd4, 0, lat, bsy);
        check("mul_3_4_lo", 64'(lo), 64'd12);
        check("mul_3_4_hi", 64'(hi), 64'd0);
        check("mul_3_4_dz", 64'(div_zero), 64'd0);

        @(negedge clk);
        start = 1'b1;
        alu_decode = 4'b0001;
        rda = 32'd77;
        rdx = 32'd88;
        @(negedge clk);
        start = 1'b0;
        bsy = 0;
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy) bsy++;
            if (done) lat++;
            @(negedge clk);
        end
        check("badop_busy", 64'(bsy), 64'd0);
        check("badop_done", 64'(lat), 64'd0);
        check("badop_lo", 64'(lo), 64'd12);
        check("badop_hi", 64'(hi), 64'd0);

        run_op(4'd5, 32'd2, 32'd3, 3, lat, bsy);
        check("mul_2_3_lat", 64'(lat), 64'd33);
        check("mul_2_3_lo", 64'(lo), 64'd6);
        run_op(4'd6, 32'd9, 32'd3, 0, lat, bsy);
        check("b2b_div_lat", 64'(lat), 64'd33);
        check("b2b_div_lo", 64'(lo), 64'd3);
        check("b2b_div_hi", 64'(hi), 64'd0);

        @(negedge clk);
        start = 1'b1;
        alu_decode = 4'd5;
        rda = 32'h1234;
        rdx = 32'h5678;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(4'd5, 32'd7, 32'd6, 0, lat, bsy);
        check("post_rst_lat", 64'(lat), 64'd33);
        check("post_rst_lo", 64'(lo), 64'd42);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

endmodule
